// File: rtl/stage_reporter_pkg.sv
// Shared constants and types for the stage reporter: register offsets,
// control bit positions, well-known stage codes and the display FSM states.
package stage_reporter_pkg;

  localparam logic [3:0] STAGE_OFS = 4'h0;
  localparam logic [3:0] CTRL_OFS  = 4'h4;

  localparam int ERR_BIT   = 8;
  localparam int FLUSH_BIT = 0;

  typedef logic [4:0] stage_t;

  localparam stage_t STAGE_BEGIN = 5'd31;
  localparam stage_t STAGE_PASS  = 5'd30;

  typedef enum logic {
    DISP_IDLE = 1'b0,
    DISP_HOLD = 1'b1
  } disp_state_t;

  // Layout of the STAGE register as seen by a read.
  function automatic logic [31:0] stage_read_word(input stage_t     stage,
                                                  input logic       err,
                                                  input logic       busy,
                                                  input logic [3:0] count);
    return {20'd0, count, 1'b0, busy, err, stage};
  endfunction

endpackage

// File: rtl/stage_reporter_if.sv
// Wishbone slave bundle for the stage reporter. Signal names keep the
// wrapper-level wbs_* naming so they map one-to-one onto the user project bus.
interface stage_reporter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/stage_fifo.sv
// Small synchronous FIFO of pending stage codes. Read data is the head entry
// (combinational), so a pop takes the displayed value in the same cycle.
// A push into a full FIFO is allowed when a pop happens in the same cycle.
module stage_fifo
  import stage_reporter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  stage_t           din,
  output stage_t           dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  stage_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage array, no reset needed: only entries counted as valid are read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy tracking; flush discards everything queued.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/stage_reporter.sv
// Wishbone-writable stage/error reporter. Stage codes are queued and each one
// is shown on status_o for HOLD_CYCLES cycles so a slow external sampler sees
// every code; the error flag is sticky and bypasses the queue.
module stage_reporter
  import stage_reporter_pkg::*;
#(
  parameter int     HOLD_CYCLES = 256,
  parameter int     FIFO_DEPTH  = 4,
  parameter stage_t RESET_CODE  = 5'd0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  stage_reporter_if.slave  wb,
  output logic [5:0]       status_o,
  output logic [5:0]       status_oeb,
  output logic             busy_o
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  disp_state_t       state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  stage_t            stage_reg, stage_next;
  logic              err_reg, err_next;
  logic              ack_reg;
  logic [31:0]       dat_reg, dat_next;

  logic              wb_req;
  logic              sel_ctrl;
  logic              stage_wr;
  logic              wb_accept;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  stage_t            fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              unused_bits;
  assign unused_bits = ^{wb.wbs_adr_i[3], wb.wbs_adr_i[1:0],
                         wb.wbs_dat_i[31:9], wb.wbs_dat_i[7:5]};

  stage_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wb.wbs_dat_i[4:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign status_o     = {err_reg, stage_reg};
  assign status_oeb   = 6'b000000;
  assign busy_o       = (state_reg == DISP_HOLD) | (fifo_count != '0);
  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = dat_reg;

  // Bus decode: a STAGE write only completes when a slot is free or one is
  // being freed by the display this same cycle; otherwise ack is withheld.
  always_comb begin
    wb_req     = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_reg;
    sel_ctrl   = (wb.wbs_adr_i[2] == CTRL_OFS[2]);
    stage_wr   = wb_req & wb.wbs_we_i & ~sel_ctrl;
    wb_accept  = wb_req & (~stage_wr | ~fifo_full | fifo_pop);
    fifo_push  = wb_accept & stage_wr;
    fifo_flush = wb_accept & wb.wbs_we_i & sel_ctrl & wb.wbs_dat_i[FLUSH_BIT];
    err_next   = err_reg | (fifo_push & wb.wbs_dat_i[ERR_BIT]);
    dat_next   = '0;
    if (wb_accept && !wb.wbs_we_i && !sel_ctrl) begin
      dat_next = stage_read_word(stage_reg, err_reg, busy_o, 4'(fifo_count));
    end
  end

  // Display FSM: pop a code, hold it for HOLD_CYCLES, chain into the next one.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      DISP_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          hold_cnt_next = HOLD_RELOAD;
          state_next    = DISP_HOLD;
        end
      end
      DISP_HOLD: begin
        if (hold_cnt_reg == '0) begin
          if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            hold_cnt_next = HOLD_RELOAD;
          end else begin
            state_next = DISP_IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
      end
      default: state_next = DISP_IDLE;
    endcase
    stage_next = fifo_pop ? fifo_dout : stage_reg;
  end

  // Display state registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= DISP_IDLE;
      hold_cnt_reg <= '0;
      stage_reg    <= RESET_CODE;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      stage_reg    <= stage_next;
      err_reg      <= err_next;
    end
  end

  // Registered one-cycle ack and read data, zero outside the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
    end else begin
      ack_reg <= wb_accept;
      dat_reg <= dat_next;
    end
  end

endmodule
